// File: rtl/vram_write_scheduler_pkg.sv
// Shared definitions for the VRAM write scheduler: FSM state encodings,
// default widths and the opcode the CPU pixel write is decoded from.
package vram_write_scheduler_pkg;

  localparam int VWS_COORD_W = 8;
  localparam int VWS_COLOR_W = 3;

  // Opcode of the MiniAlu instruction that produces a CPU pixel write
  localparam logic [7:0] VWS_VGA_OPCODE = 8'h0A;

  typedef enum logic [1:0] {
    VWS_IDLE  = 2'd0,
    VWS_FILL  = 2'd1,
    VWS_CLEAR = 2'd2
  } vws_state_t;

endpackage

// File: rtl/vram_write_scheduler_if.sv
// Bus between the execute stage and the VRAM write scheduler: CPU pixel
// writes, fill requests, fill status and the video RAM write port.
interface vram_write_scheduler_if #(
  parameter int COORD_W = vram_write_scheduler_pkg::VWS_COORD_W,
  parameter int COLOR_W = vram_write_scheduler_pkg::VWS_COLOR_W
);
  logic                   cpu_we;
  logic [COORD_W-1:0]     cpu_x;
  logic [COORD_W-1:0]     cpu_y;
  logic [COLOR_W-1:0]     cpu_color;
  logic                   fill_start;
  logic [COORD_W-1:0]     fill_x0;
  logic [COORD_W-1:0]     fill_y0;
  logic [COORD_W-1:0]     fill_w;
  logic [COORD_W-1:0]     fill_h;
  logic [COLOR_W-1:0]     fill_color;
  logic                   fill_busy;
  logic                   fill_done;
  logic                   vram_we;
  logic [2*COORD_W-1:0]   vram_addr;
  logic [COLOR_W-1:0]     vram_data;

  modport master (
    output cpu_we, cpu_x, cpu_y, cpu_color,
    output fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_color,
    input  fill_busy, fill_done, vram_we, vram_addr, vram_data
  );

  modport slave (
    input  cpu_we, cpu_x, cpu_y, cpu_color,
    input  fill_start, fill_x0, fill_y0, fill_w, fill_h, fill_color,
    output fill_busy, fill_done, vram_we, vram_addr, vram_data
  );
endinterface

// File: rtl/vram_write_scheduler_rect_scan_counter.sv
// Nested column/row scan counter. Position outputs reflect a load in the
// same cycle, so a step issued together with the load consumes the origin.
module rect_scan_counter #(
  parameter int               COORD_W = 8,
  parameter int               EXT_W   = COORD_W + 1,
  parameter logic [EXT_W-1:0] RESET_W = '0,
  parameter logic [EXT_W-1:0] RESET_H = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] load_x0,
  input  logic [COORD_W-1:0] load_y0,
  input  logic [EXT_W-1:0]   load_w,
  input  logic [EXT_W-1:0]   load_h,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  logic [COORD_W-1:0] x0_reg, x_reg, y_reg;
  logic [EXT_W-1:0]   w_reg, h_reg, col_reg, row_reg;

  logic [COORD_W-1:0] x0_cur, x_cur, y_cur, x_next, y_next;
  logic [EXT_W-1:0]   w_cur, h_cur, col_cur, row_cur, col_next, row_next;
  logic               col_last;

  always_comb begin
    x0_cur   = load ? load_x0 : x0_reg;
    x_cur    = load ? load_x0 : x_reg;
    y_cur    = load ? load_y0 : y_reg;
    w_cur    = load ? load_w  : w_reg;
    h_cur    = load ? load_h  : h_reg;
    col_cur  = load ? '0      : col_reg;
    row_cur  = load ? '0      : row_reg;
    col_last = (col_cur == w_cur - EXT_W'(1));
    last     = col_last && (row_cur == h_cur - EXT_W'(1));
    x_next   = x_cur;
    y_next   = y_cur;
    col_next = col_cur;
    row_next = row_cur;
    if (step) begin
      if (col_last) begin
        col_next = '0;
        x_next   = x0_cur;
        row_next = row_cur + EXT_W'(1);
        y_next   = y_cur + COORD_W'(1);
      end else begin
        col_next = col_cur + EXT_W'(1);
        x_next   = x_cur + COORD_W'(1);
      end
    end
  end

  assign x = x_cur;
  assign y = y_cur;

  // Reset extents let the power-up clear start without an explicit load
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      x0_reg  <= '0;
      x_reg   <= '0;
      y_reg   <= '0;
      w_reg   <= RESET_W;
      h_reg   <= RESET_H;
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      x0_reg  <= x0_cur;
      x_reg   <= x_next;
      y_reg   <= y_next;
      w_reg   <= w_cur;
      h_reg   <= h_cur;
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

endmodule

// File: rtl/vram_write_scheduler.sv
// Arbiter for the video RAM write port: CPU pixel writes always win, the
// rectangle-fill engine stalls around them. VRAM_CLEAR_ON_RESET_EN adds a
// power-up clear of the whole RAM to colour 0.
import vram_write_scheduler_pkg::*;

module vram_write_scheduler #(
  parameter int COORD_W = VWS_COORD_W,
  parameter int COLOR_W = VWS_COLOR_W
) (
  input logic                  Clock,
  input logic                  Reset,
  vram_write_scheduler_if.slave bus
);

  localparam int EXT_W = COORD_W + 1;
`ifdef VRAM_CLEAR_ON_RESET_EN
  localparam logic [EXT_W-1:0] SCAN_RESET_EXTENT = EXT_W'(1) << COORD_W;
  localparam vws_state_t       RESET_STATE       = VWS_CLEAR;
  localparam logic             RESET_BUSY        = 1'b1;
`else
  localparam logic [EXT_W-1:0] SCAN_RESET_EXTENT = '0;
  localparam vws_state_t       RESET_STATE       = VWS_IDLE;
  localparam logic             RESET_BUSY        = 1'b0;
`endif

  vws_state_t           state_reg;
  logic                 fill_busy_reg, fill_done_reg, vram_we_reg;
  logic [2*COORD_W-1:0] vram_addr_reg;
  logic [COLOR_W-1:0]   vram_data_reg, fill_color_reg;

  logic                 fill_accept, extent_nonzero, scan_load, scan_step, scan_last;
  logic [COORD_W-1:0]   scan_x, scan_y;
  logic [2*COORD_W-1:0] pixel_addr;
  logic [COLOR_W-1:0]   pixel_color;

  assign fill_accept    = (state_reg == VWS_IDLE) && bus.fill_start;
  assign extent_nonzero = (|bus.fill_w) && (|bus.fill_h);
  assign scan_load      = fill_accept && extent_nonzero;
  // An accepted start with a free port issues the origin pixel straight away
  assign scan_step      = !bus.cpu_we &&
                          (scan_load || state_reg == VWS_FILL || state_reg == VWS_CLEAR);

  rect_scan_counter #(
    .COORD_W (COORD_W),
    .EXT_W   (EXT_W),
    .RESET_W (SCAN_RESET_EXTENT),
    .RESET_H (SCAN_RESET_EXTENT)
  ) u_scan (
    .Clock   (Clock),
    .Reset   (Reset),
    .load    (scan_load),
    .step    (scan_step),
    .load_x0 (bus.fill_x0),
    .load_y0 (bus.fill_y0),
    .load_w  ({1'b0, bus.fill_w}),
    .load_h  ({1'b0, bus.fill_h}),
    .x       (scan_x),
    .y       (scan_y),
    .last    (scan_last)
  );

  always_comb begin
    pixel_addr  = {scan_x, scan_y};
    pixel_color = scan_load ? bus.fill_color : fill_color_reg;
`ifdef VRAM_CLEAR_ON_RESET_EN
    // Clear runs row-address fastest, so the counter's inner count is y
    if (state_reg == VWS_CLEAR) begin
      pixel_addr  = {scan_y, scan_x};
      pixel_color = '0;
    end
`endif
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg      <= RESET_STATE;
      fill_busy_reg  <= RESET_BUSY;
      fill_done_reg  <= 1'b0;
      vram_we_reg    <= 1'b0;
      vram_addr_reg  <= '0;
      vram_data_reg  <= '0;
      fill_color_reg <= '0;
    end else begin
      vram_we_reg   <= 1'b0;
      fill_done_reg <= 1'b0;
      if (bus.cpu_we) begin
        vram_we_reg   <= 1'b1;
        vram_addr_reg <= {bus.cpu_x, bus.cpu_y};
        vram_data_reg <= bus.cpu_color;
      end else if (scan_step) begin
        vram_we_reg   <= 1'b1;
        vram_addr_reg <= pixel_addr;
        vram_data_reg <= pixel_color;
      end

      case (state_reg)
        VWS_IDLE: begin
          if (bus.fill_start) begin
            fill_color_reg <= bus.fill_color;
            if (!extent_nonzero) begin
              fill_done_reg <= 1'b1;
            end else if (scan_step && scan_last) begin
              fill_done_reg <= 1'b1;
            end else begin
              state_reg     <= VWS_FILL;
              fill_busy_reg <= 1'b1;
            end
          end
        end
        VWS_FILL: begin
          if (scan_step && scan_last) begin
            state_reg     <= VWS_IDLE;
            fill_busy_reg <= 1'b0;
            fill_done_reg <= 1'b1;
          end
        end
`ifdef VRAM_CLEAR_ON_RESET_EN
        VWS_CLEAR: begin
          if (scan_step && scan_last) begin
            state_reg     <= VWS_IDLE;
            fill_busy_reg <= 1'b0;
          end
        end
`endif
        default: begin
          state_reg     <= VWS_IDLE;
          fill_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fill_busy = fill_busy_reg;
  assign bus.fill_done = fill_done_reg;
  assign bus.vram_we   = vram_we_reg;
  assign bus.vram_addr = vram_addr_reg;
  assign bus.vram_data = vram_data_reg;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Scoreboard bench for vram_write_scheduler: expected port writes and done
// pulses are queued with their cycle when stimulus is driven.
module tb_vram_write_scheduler;

  typedef struct {
    int          cyc;
    logic        we;
    logic [15:0] addr;
    logic [2:0]  data;
    logic        done;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;
  exp_t sb[$];

  vram_write_scheduler_if #(.COORD_W(8), .COLOR_W(3)) bus ();

  vram_write_scheduler #(.COORD_W(8), .COLOR_W(3)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic expect_out(input int c, input logic we, input logic [15:0] addr,
                            input logic [2:0] data, input logic done);
    exp_t e;
    e.cyc = c; e.we = we; e.addr = addr; e.data = data; e.done = done;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(negedge Clock);
    bus.cpu_we     = 1'b0;
    bus.fill_start = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
    bus.cpu_we = 1'b1; bus.cpu_x = x; bus.cpu_y = y; bus.cpu_color = c;
    $display("cycle %0d: cpu write (%0d,%0d) colour %0d", cyc, x, y, c);
  endtask

  task automatic fill_req(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] w,
                          input logic [7:0] h, input logic [2:0] c);
    bus.fill_start = 1'b1; bus.fill_x0 = x0; bus.fill_y0 = y0;
    bus.fill_w = w; bus.fill_h = h; bus.fill_color = c;
    $display("cycle %0d: fill request (%0d,%0d) %0dx%0d colour %0d", cyc, x0, y0, w, h, c);
  endtask

  // Expected pixel sequence of an unobstructed fill, x fastest, modulo 256
  task automatic expect_fill(input int c0, input int x0, input int y0, input int w,
                             input int h, input logic [2:0] c);
    int k = 0;
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        k++;
        expect_out(c0 + k, 1'b1, {8'((x0 + i) % 256), 8'((y0 + j) % 256)}, c, k == w * h);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      next_cycle();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    next_cycle();
  endtask

  always @(negedge Clock) begin
    if (mon_en && !Reset && (bus.vram_we || bus.fill_done)) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {30'd0, bus.vram_we, bus.fill_done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (sb.size() < 4 || e.cyc % 4096 == 0)
          $display("cycle %0d: out we=%0d addr=0x%04h data=%0d done=%0d", cyc,
                   bus.vram_we, bus.vram_addr, bus.vram_data, bus.fill_done);
        check("out_cycle", cyc, e.cyc);
        check("vram_we", bus.vram_we, e.we);
        if (e.we) begin
          check("vram_addr", bus.vram_addr, e.addr);
          check("vram_data", bus.vram_data, e.data);
        end
        check("fill_done", bus.fill_done, e.done);
      end
    end
  end

  initial begin
    int c;
    bus.cpu_we = 0; bus.cpu_x = 0; bus.cpu_y = 0; bus.cpu_color = 0;
    bus.fill_start = 0; bus.fill_x0 = 0; bus.fill_y0 = 0;
    bus.fill_w = 0; bus.fill_h = 0; bus.fill_color = 0;

    repeat (3) next_cycle();
    check("rst_we", bus.vram_we, 0);
    check("rst_addr", bus.vram_addr, 0);
    check("rst_data", bus.vram_data, 0);
    check("rst_done", bus.fill_done, 0);
`ifdef VRAM_CLEAR_ON_RESET_EN
    check("rst_busy", bus.fill_busy, 1);
    Reset = 1'b0;
    c = cyc;
    for (int i = 0; i < 65536; i++) expect_out(c + 1 + i, 1'b1, 16'(i), 3'd0, 1'b0);
    next_cycle();
    check("clear_busy", bus.fill_busy, 1);
    while (cyc < c + 65536) next_cycle();
    check("clear_end_busy", bus.fill_busy, 0);
    drain(10);
`else
    check("rst_busy", bus.fill_busy, 0);
    Reset = 1'b0;
    next_cycle();
`endif

    // CPU write alone
    next_cycle(); c = cyc;
    cpu_write(8'd10, 8'd20, 3'd5);
    expect_out(c + 1, 1'b1, 16'h0A14, 3'd5, 1'b0);
    drain(10);

    // Small fill, busy timing around it
    next_cycle(); c = cyc;
    fill_req(8'd3, 8'd4, 8'd2, 8'd2, 3'd6);
    expect_fill(c, 3, 4, 2, 2, 3'd6);
    next_cycle();
    check("fill_busy_start", bus.fill_busy, 1);
    while (cyc < c + 4) next_cycle();
    check("fill_busy_last", bus.fill_busy, 0);
    drain(10);

    // CPU pre-empts the second fill cycle
    next_cycle(); c = cyc;
    fill_req(8'd3, 8'd4, 8'd2, 8'd2, 3'd6);
    expect_out(c + 1, 1'b1, 16'h0304, 3'd6, 1'b0);
    next_cycle();
    cpu_write(8'd0, 8'd0, 3'd1);
    expect_out(c + 2, 1'b1, 16'h0000, 3'd1, 1'b0);
    expect_out(c + 3, 1'b1, 16'h0404, 3'd6, 1'b0);
    expect_out(c + 4, 1'b1, 16'h0305, 3'd6, 1'b0);
    expect_out(c + 5, 1'b1, 16'h0405, 3'd6, 1'b1);
    drain(20);

    // Wrap across the right edge
    next_cycle(); c = cyc;
    fill_req(8'd254, 8'd0, 8'd3, 8'd1, 3'd2);
    expect_out(c + 1, 1'b1, 16'hFE00, 3'd2, 1'b0);
    expect_out(c + 2, 1'b1, 16'hFF00, 3'd2, 1'b0);
    expect_out(c + 3, 1'b1, 16'h0000, 3'd2, 1'b1);
    drain(10);

    // Zero extents: done only
    next_cycle(); c = cyc;
    fill_req(8'd5, 8'd5, 8'd0, 8'd3, 3'd7);
    expect_out(c + 1, 1'b0, 16'h0000, 3'd0, 1'b1);
    next_cycle();
    check("zero_busy", bus.fill_busy, 0);
    drain(10);
    next_cycle(); c = cyc;
    fill_req(8'd5, 8'd5, 8'd4, 8'd0, 3'd7);
    expect_out(c + 1, 1'b0, 16'h0000, 3'd0, 1'b1);
    drain(10);

    // Start together with a CPU write
    next_cycle(); c = cyc;
    cpu_write(8'd1, 8'd2, 3'd7);
    fill_req(8'd10, 8'd10, 8'd1, 8'd2, 3'd4);
    expect_out(c + 1, 1'b1, 16'h0102, 3'd7, 1'b0);
    expect_out(c + 2, 1'b1, 16'h0A0A, 3'd4, 1'b0);
    expect_out(c + 3, 1'b1, 16'h0A0B, 3'd4, 1'b1);
    next_cycle();
    check("same_cycle_busy", bus.fill_busy, 1);
    drain(10);

    // Second start mid-fill is ignored; wraps across the bottom edge too
    next_cycle(); c = cyc;
    fill_req(8'd100, 8'd255, 8'd3, 8'd2, 3'd3);
    expect_fill(c, 100, 255, 3, 2, 3'd3);
    next_cycle(); next_cycle();
    fill_req(8'd0, 8'd0, 8'd1, 8'd1, 3'd7);
    drain(20);
    check("after_ignore_busy", bus.fill_busy, 0);

    // Reset mid-fill aborts with no done pulse
    next_cycle(); c = cyc;
    fill_req(8'd50, 8'd60, 8'd4, 8'd4, 3'd2);
    expect_out(c + 1, 1'b1, {8'd50, 8'd60}, 3'd2, 1'b0);
    expect_out(c + 2, 1'b1, {8'd51, 8'd60}, 3'd2, 1'b0);
    next_cycle(); next_cycle();
    #1 Reset = 1'b1;
    $display("cycle %0d: reset asserted mid-fill", cyc);
    #1;
    check("abort_we", bus.vram_we, 0);
    check("abort_addr", bus.vram_addr, 0);
    check("abort_data", bus.vram_data, 0);
    check("abort_done", bus.fill_done, 0);
    check("abort_sb", sb.size(), 0);
    sb.delete();
    next_cycle(); next_cycle();
    Reset = 1'b0;
`ifdef VRAM_CLEAR_ON_RESET_EN
    mon_en = 1'b0;
    next_cycle();
    check("abort_clear_busy", bus.fill_busy, 1);
`else
    repeat (10) begin
      next_cycle();
      check("abort_no_done", bus.fill_done, 0);
    end
    check("abort_idle_busy", bus.fill_busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
